// File: rtl/mem_port_bridge.sv
// Bridges a level-held CPU memory bus to a single-request, variable-latency memory port.
// One access in flight at a time; completed reads are held on the shared data bus until readM drops.
module mem_port_bridge #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_valid,
  output logic                 bus_error,
  output logic [WORD_SIZE-1:0] access_count
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, HOLD} state_t;

  // Last WAIT count before abort: the TIMEOUT-th WAIT edge without mem_valid fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic                 is_write;
  logic                 timed_out;
  logic                 wait_to;
  logic                 drive;
  logic [7:0]           tcnt;
  logic [WORD_SIZE-1:0] rbuf;

  always_comb begin
    state_nxt = state;
    wait_to   = 1'b0;
    case (state)
      IDLE: if (readM ^ writeM) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT: begin
        // mem_valid wins over the timeout on the same edge
        if (mem_valid) state_nxt = DONE;
        else if (tcnt == TO_LAST) begin
          state_nxt = DONE;
          wait_to   = 1'b1;
        end
      end
      DONE: state_nxt = HOLD;
      HOLD: if (!readM && !writeM) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && is_write;
  assign mem_ready = (state == DONE);

  // readM is used directly so the bus releases the moment the CPU drops the read.
  assign drive = ((state == DONE) || (state == HOLD)) && !is_write && readM;
  assign data  = drive ? rbuf : {WORD_SIZE{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      timed_out    <= 1'b0;
      tcnt         <= '0;
      rbuf         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      bus_error    <= 1'b0;
      access_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (readM && writeM) bus_error <= 1'b1;
          else if (readM || writeM) begin
            mem_addr  <= address;
            is_write  <= writeM;
            timed_out <= 1'b0;
            if (writeM) mem_wdata <= data;
          end
        end
        REQ: tcnt <= '0;
        WAIT: begin
          if (mem_valid) begin
            if (!is_write) rbuf <= mem_rdata;
          end else if (wait_to) begin
            bus_error <= 1'b1;
            timed_out <= 1'b1;
            if (!is_write) rbuf <= '1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: if (!timed_out) access_count <= access_count + WORD_SIZE'(1);
        default: ;
      endcase
    end
  end
endmodule
